// File: rtl/mips_pkg.sv
// Shared pipeline types: hazard-controller action encoding and scoreboard entry.
package mips_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_STALL  = 2'd1,
        HZ_FLUSH  = 2'd2,
        HZ_FREEZE = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard (EX, MEM, WB) with RAW match comparators.
// HAZARD_RF_BYPASS_EN: register file writes before reads, so WB is not compared.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             new_vld,
    input  logic [REG_W-1:0] new_dest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             match_rs,
    output logic             match_rt
);

`ifdef HAZARD_RF_BYPASS_EN
    localparam int NCMP = 2;
`else
    localparam int NCMP = 3;
`endif

    // [0]=EX, [1]=MEM, [2]=WB
    sb_entry_t [2:0] sb_q;
    sb_entry_t       sb_new;

    always_comb begin
        sb_new       = '0;
        sb_new.valid = new_vld;
        sb_new.dest  = new_dest;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else if (shift_en) begin
            sb_q[2] <= sb_q[1];
            sb_q[1] <= sb_q[0];
            sb_q[0] <= sb_new;
        end
    end

    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        for (int i = 0; i < NCMP; i++) begin
            if (sb_q[i].valid && (sb_q[i].dest == rs) && (rs != '0)) match_rs = 1'b1;
            if (sb_q[i].valid && (sb_q[i].dest == rt) && (rt != '0)) match_rt = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze controller for the non-forwarding 5-stage MIPS pipeline.
// HAZARD_RF_BYPASS_EN (in hazard_scoreboard) shortens the RAW stall to 2 cycles.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W = mips_pkg::REG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_dest,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    logic       match_rs, match_rt, raw, freeze, new_vld;
    hz_state_e  act, hz_state_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    assign freeze  = dmem_req & ~dmem_ack;
    assign raw     = id_valid & ((id_use_rs & match_rs) | (id_use_rt & match_rt));
    // Only an instruction that actually advances into EX becomes a pending write.
    assign new_vld = (act == HZ_RUN) & id_valid & id_regwrite & (id_dest != '0);

    hazard_scoreboard #(.REG_W(REG_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .shift_en (~freeze),
        .new_vld  (new_vld),
        .new_dest (id_dest),
        .rs       (id_rs),
        .rt       (id_rt),
        .match_rs (match_rs),
        .match_rt (match_rt)
    );

    always_comb begin
        if (freeze)           act = HZ_FREEZE;
        else if (ex_redirect) act = HZ_FLUSH;
        else if (raw)         act = HZ_STALL;
        else                  act = HZ_RUN;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        case (act)
            HZ_FREEZE: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                pipe_hold = 1'b1;
            end
            HZ_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            HZ_STALL: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
        // Hold the front end empty while reset is asserted.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hz_state_q   <= HZ_RUN;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            hz_state_q <= act;
            case (act)
                HZ_STALL:  stall_cnt_q  <= stall_cnt_q + 1'b1;
                HZ_FLUSH:  flush_cnt_q  <= flush_cnt_q + 1'b1;
                HZ_FREEZE: freeze_cnt_q <= freeze_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign hz_state   = hz_state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;
`ifdef HAZARD_RF_BYPASS_EN
    localparam int NCMP = 2;
`else
    localparam int NCMP = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_rs, id_use_rt, id_regwrite;
    logic [4:0] id_rs, id_rt, id_dest;
    logic ex_redirect, dmem_req, dmem_ack;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold;
    logic [1:0] hz_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regwrite(id_regwrite), .id_dest(id_dest),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .hz_state(hz_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    wire [4:0] ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_hold};

    int ncmp = 0;
    int nfail = 0;

    // Model: list of pending destination registers, youngest first (-1 = none).
    int q[$];
    logic [CNT_W-1:0] e_stall, e_flush, e_freeze;
    int e_hz;

    function automatic bit pending(input int r);
        if (r == 0) return 1'b0;
        for (int i = 0; i < NCMP; i++) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // 0 run, 1 stall, 2 flush, 3 freeze
    function automatic int m_act();
        bit raw;
        if (dmem_req && !dmem_ack) return 3;
        if (ex_redirect) return 2;
        raw = id_valid && ((id_use_rs && pending(int'(id_rs))) || (id_use_rt && pending(int'(id_rt))));
        return raw ? 1 : 0;
    endfunction

    function automatic logic [4:0] ctl_of(input int a);
        case (a)
            0: return 5'b11000;
            1: return 5'b00010;
            2: return 5'b11110;
            default: return 5'b00001;
        endcase
    endfunction

    task automatic m_reset();
        q = '{-1, -1, -1};
        e_stall = '0; e_flush = '0; e_freeze = '0; e_hz = 0;
    endtask

    task automatic tick();
        int a;
        int nv;
        a = m_act();
        if (a != 3) begin
            nv = (a == 0 && id_valid && id_regwrite && id_dest != 0) ? int'(id_dest) : -1;
            q.push_front(nv);
            void'(q.pop_back());
        end
        if (a == 1) e_stall++;
        if (a == 2) e_flush++;
        if (a == 3) e_freeze++;
        e_hz = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_regwrite = 0;
        id_rs = 0; id_rt = 0; id_dest = 0;
        ex_redirect = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                          input logic urt, input logic rw, input logic [4:0] dest);
        id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_regwrite = rw; id_dest = dest;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        m_reset();
        #12;
        ncmp++;
        if (ctl !== 5'b00110) begin
            $display("FAIL reset_ctl got=%b want=%b", ctl, 5'b00110); nfail++;
        end
        ncmp++;
        if (hz_state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || freeze_cnt !== 0) begin
            $display("FAIL reset_state hz=%0d st=%0d fl=%0d fr=%0d want all 0",
                     hz_state, stall_cnt, flush_cnt, freeze_cnt); nfail++;
        end
        @(negedge clk);
        rst = 1;
        #1;
        ncmp++;
        if (ctl !== 5'b11000) begin
            $display("FAIL post_reset_run got=%b want=%b", ctl, 5'b11000); nfail++;
        end
        @(negedge clk);
    endtask

    task automatic test_raw_stall();
        logic [CNT_W-1:0] s0;
        int n;
        drain();
        s0 = stall_cnt;
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
        #1;
        ncmp++;
        if (ctl !== 5'b11000) begin
            $display("FAIL producer_run got=%b want=%b", ctl, 5'b11000); nfail++;
        end
        tick();
        set_id(5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd4);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            ncmp++;
            if (ctl !== ctl_of(m_act())) begin
                $display("FAIL raw_ctl cyc=%0d got=%b want=%b", i, ctl, ctl_of(m_act())); nfail++;
            end
            if (pc_en !== 1'b0) break;
            n++;
            tick();
        end
        ncmp++;
        if (n != NCMP) begin
            $display("FAIL raw_stall_len got=%0d want=%0d", n, NCMP); nfail++;
        end
        ncmp++;
        if (stall_cnt !== s0 + NCMP || hz_state !== 2'd1) begin
            $display("FAIL raw_stall_cnt got=%0d hz=%0d want=%0d hz=1", stall_cnt, hz_state, s0 + NCMP);
            nfail++;
        end
        tick();
    endtask

    task automatic test_reg0();
        logic [CNT_W-1:0] s0;
        drain();
        s0 = stall_cnt;
        set_id(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd0);
        tick();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd6);
        #1;
        ncmp++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            $display("FAIL reg0_nostall pc_en=%b bubble=%b want 1/0", pc_en, idex_bubble); nfail++;
        end
        tick();
        ncmp++;
        if (stall_cnt !== s0) begin
            $display("FAIL reg0_cnt got=%0d want=%0d", stall_cnt, s0); nfail++;
        end
    endtask

    task automatic test_redirect_raw();
        logic [CNT_W-1:0] f0, s0;
        drain();
        f0 = flush_cnt; s0 = stall_cnt;
        set_id(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd7);
        tick();
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8);
        ex_redirect = 1;
        #1;
        ncmp++;
        if (ctl !== 5'b11110) begin
            $display("FAIL redirect_ctl got=%b want=%b", ctl, 5'b11110); nfail++;
        end
        tick();
        idle();
        #1;
        ncmp++;
        if (pc_en !== 1'b1 || hz_state !== 2'd2) begin
            $display("FAIL redirect_after pc_en=%b hz=%0d want 1/2", pc_en, hz_state); nfail++;
        end
        ncmp++;
        if (flush_cnt !== f0 + 1 || stall_cnt !== s0) begin
            $display("FAIL redirect_cnt fl=%0d st=%0d want %0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
            nfail++;
        end
        tick();
    endtask

    task automatic test_freeze();
        logic [CNT_W-1:0] z0;
        int n;
        drain();
        z0 = freeze_cnt;
        set_id(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd9);
        tick();
        idle();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            ncmp++;
            if (pc_en !== 1'b0 || pipe_hold !== 1'b1 || ifid_en !== 1'b0) begin
                $display("FAIL freeze_ctl cyc=%0d got=%b want=%b", i, ctl, 5'b00001); nfail++;
            end
            tick();
        end
        ncmp++;
        if (freeze_cnt !== z0 + 4 || hz_state !== 2'd3) begin
            $display("FAIL freeze_cnt got=%0d hz=%0d want=%0d hz=3", freeze_cnt, hz_state, z0 + 4);
            nfail++;
        end
        // Producer must still sit in EX: the consumer stalls the full window starting on the ack cycle.
        dmem_ack = 1;
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            ncmp++;
            if (ctl !== ctl_of(m_act())) begin
                $display("FAIL unfreeze_ctl cyc=%0d got=%b want=%b", i, ctl, ctl_of(m_act())); nfail++;
            end
            if (pc_en !== 1'b0) break;
            n++;
            tick();
            dmem_req = 0; dmem_ack = 0;
        end
        ncmp++;
        if (n != NCMP) begin
            $display("FAIL unfreeze_stall_len got=%0d want=%0d", n, NCMP); nfail++;
        end
        tick();
    endtask

    task automatic test_freeze_redirect();
        drain();
        dmem_req = 1; ex_redirect = 1;
        #1;
        ncmp++;
        if (ctl !== 5'b00001) begin
            $display("FAIL frz_redir_ctl got=%b want=%b", ctl, 5'b00001); nfail++;
        end
        tick();
        dmem_ack = 1;
        #1;
        ncmp++;
        if (ctl !== 5'b11110 || hz_state !== 2'd3) begin
            $display("FAIL frz_redir_resume got=%b hz=%0d want=%b hz=3", ctl, hz_state, 5'b11110); nfail++;
        end
        tick();
        ncmp++;
        if (hz_state !== 2'd2) begin
            $display("FAIL frz_redir_hz got=%0d want=2", hz_state); nfail++;
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 5'd12);
        tick();
        set_id(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13);
        #1;
        ncmp++;
        if (ctl !== 5'b00010) begin
            $display("FAIL pre_reset_stall got=%b want=%b", ctl, 5'b00010); nfail++;
        end
        #1 rst = 0;
        #1;
        ncmp++;
        if (ctl !== 5'b00110 || hz_state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || freeze_cnt !== 0) begin
            $display("FAIL mid_reset got=%b hz=%0d st=%0d want=%b hz=0 st=0", ctl, hz_state, stall_cnt, 5'b00110);
            nfail++;
        end
        m_reset();
        @(negedge clk);
        rst = 1;
        #1;
        ncmp++;
        if (ctl !== 5'b11000) begin
            $display("FAIL post_reset_consumer got=%b want=%b", ctl, 5'b11000); nfail++;
        end
        tick();
        ncmp++;
        if (hz_state !== 2'd0 || stall_cnt !== 0) begin
            $display("FAIL post_reset_hz hz=%0d st=%0d want 0/0", hz_state, stall_cnt); nfail++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = 5'($urandom_range(0, 7));
            id_rt       = 5'($urandom_range(0, 7));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_regwrite = 1'($urandom_range(0, 1));
            id_dest     = 5'($urandom_range(0, 7));
            ex_redirect = ($urandom_range(0, 7) == 0);
            dmem_req    = ($urandom_range(0, 3) == 0);
            dmem_ack    = 1'($urandom_range(0, 1));
            #1;
            ncmp++;
            if (ctl !== ctl_of(m_act()) || hz_state !== 2'(e_hz)) begin
                $display("FAIL rand_ctl cyc=%0d got=%b hz=%0d want=%b hz=%0d", i, ctl, hz_state, ctl_of(m_act()), e_hz);
                nfail++;
            end
            ncmp++;
            if (stall_cnt !== e_stall || flush_cnt !== e_flush || freeze_cnt !== e_freeze) begin
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                         stall_cnt, flush_cnt, freeze_cnt, e_stall, e_flush, e_freeze);
                nfail++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_reg0();
        test_redirect_raw();
        test_freeze();
        test_freeze_redirect();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline without forwarding. It tracks in-flight register writes in a small scoreboard and stalls decode on read-after-write hazards. It flushes fetch/decode on a taken branch or jump resolved in EX, and freezes the whole pipeline while a data-memory access is outstanding. It sits beside `datapath` and drives that module's pipeline-register enables and flush/bubble controls.

## Interface
- `REG_W`, 5: register-index width.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W  source registers of the ID instruction.
- `id_use_rs`, `id_use_rt`  in  1  the ID instruction actually reads rs / rt.
- `id_regwrite`  in  1  the ID instruction writes a register.
- `id_dest`  in  REG_W  destination after the RegDst mux.
- `ex_redirect`  in  1  the EX branch is taken or the EX jump is active.
- `dmem_req`  in  1  the MEM stage has a load or store pending.
- `dmem_ack`  in  1  data memory completes the access this cycle.
- `pc_en`  out  1  PC may update.
- `ifid_en`  out  1  the IF/ID register may load.
- `ifid_flush`  out  1  clear IF/ID to a NOP.
- `idex_bubble`  out  1  load a NOP into ID/EX.
- `pipe_hold`  out  1  ID/EX, EX/MEM and MEM/WB hold.
- `hz_state`  out  2  last-cycle action: RUN=0, STALL=1, FLUSH=2, FREEZE=3.
- `stall_cnt`, `flush_cnt`, `freeze_cnt`  out  CNT_W  event counters.

## Operation
- **Scoreboard:** 3 entries (EX, MEM, WB), each {valid, dest}. On each non-frozen edge it shifts EX→MEM→WB, and EX loads the new entry.
  - New entry = {id_valid & id_regwrite & (id_dest≠0) & ~stall & ~redirect, id_dest}.
  - A bubble loads valid=0.
- **Hazard term:** `raw` = id_valid & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt))).
  - `match(r)` = r≠0 and r equals the dest of any valid entry in the compared stages.
  - Register 0 never hazards.
- **Priority, evaluated combinationally each cycle:**
  - **FREEZE** (`dmem_req & ~dmem_ack`): pc_en=0, ifid_en=0, pipe_hold=1, flush=bubble=0, scoreboard holds.
  - **FLUSH** (`ex_redirect`): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, scoreboard shifts in invalid. A concurrent raw is ignored because the ID instruction is killed.
  - **STALL** (`raw`): pc_en=0, ifid_en=0, idex_bubble=1, scoreboard shifts in invalid.
  - **RUN**: pc_en=1, ifid_en=1, all other controls 0.
- `hz_state` registers the action taken on each edge.
- Counters increment once per cycle spent in STALL, FLUSH or FREEZE respectively. They wrap modulo 2^CNT_W.

## Timing
- Control outputs are combinational from inputs plus the registered scoreboard. There is zero-cycle decision latency.
- Without bypass, a dependent instruction directly after its producer stalls 3 cycles: while the producer is in EX, MEM and WB.
- A redirect costs exactly 2 squashed slots (IF/ID and ID/EX).
- A freeze lasts until the cycle `dmem_ack`=1 and resumes in the same cycle. `dmem_ack` without `dmem_req` is ignored.
- **Reset (rst=0), asynchronous:**
  - Scoreboard entries are invalid, hz_state=RUN and all counters are 0.
  - While reset is asserted, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
  - Reset mid-stall drops all pending entries. The first cycle after release is RUN.

## Configuration
- `HAZARD_RF_BYPASS_EN` defined: the register file has write-before-read semantics. The WB entry is excluded from `match`, so the back-to-back dependency stall is 2 cycles.
- Not defined: all three entries are compared and the stall is 3 cycles.

## Structure
- Shared package `mips_pkg`:
  - hz_state enum (RUN/STALL/FLUSH/FREEZE).
  - REG_W constant.
  - Scoreboard entry struct {valid, dest}.
- Natural sub-module: `hazard_scoreboard`, containing the 3-entry shift register and the `match` comparators with the macro-controlled WB compare. The top module holds the priority logic and counters.

## Test plan
- `add $3,…` then `sub $4,$3,$5` (rs=3), no bypass → exactly 3 STALL cycles, then RUN; stall_cnt=3. With `HAZARD_RF_BYPASS_EN` → 2 cycles.
- Producer writes $0, consumer reads $0 → no stall; stall_cnt stays 0.
- ex_redirect=1 while ID has a raw hazard → ifid_flush=1, idex_bubble=1, pc_en=1 that cycle; flush_cnt=1; no stall follows.
- dmem_req=1 with dmem_ack low for 4 cycles → pc_en=0 and pipe_hold=1 for 4 cycles, scoreboard unchanged, freeze_cnt=4. On ack the scoreboard resumes shifting.
- FREEZE and ex_redirect together → FREEZE wins; the flush occurs on the first unfrozen cycle.
- Assert rst during a STALL with a valid EX entry → outputs take their reset values at once; after release a consumer of that register runs with no stall.
